// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. ADD/SUB/AND/OR finish in one cycle; MUL (and SDIV/UDIV) iterate WIDTH cycles.
// Optional macro ALU_MC_DIV_EN builds the restoring divider; without it SDIV/UDIV behave as the reserved op.

module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             done,
  output logic             busy,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SDIV = 3'b100;
  localparam logic [2:0] OP_UDIV = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_done;
  logic             r_busy;
  logic             r_dz;

  logic             w_accept;
  logic             w_multi;
  logic             w_last;
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_fast_res;
  logic             w_fast_c;
  logic             w_fast_v;
  logic [3:0]       w_fast_flags;
  logic [WIDTH-1:0] w_mul_p;
  logic [WIDTH-1:0] w_ld_q;
  logic [WIDTH-1:0] w_ld_d;
  logic [WIDTH-1:0] w_p_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_d_nxt;
  logic [WIDTH-1:0] w_run_res;
  logic [3:0]       w_run_flags;
  logic             w_run_dz;

  function automatic logic is_multi(input logic [2:0] f_op);
    case (f_op)
      OP_MUL:           is_multi = 1'b1;
`ifdef ALU_MC_DIV_EN
      OP_SDIV, OP_UDIV: is_multi = 1'b1;
`endif
      default:          is_multi = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] nz_flags(input logic [WIDTH-1:0] f_res, input logic f_c, input logic f_v);
    nz_flags = {f_res[WIDTH-1], (f_res == {WIDTH{1'b0}}), f_c, f_v};
  endfunction

  assign w_accept = start & (r_state != S_RUN);
  assign w_multi  = is_multi(op);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Next-state logic; DONE falls back to IDLE unless a new start is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_multi ? S_RUN : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Single-cycle operations; SUB is a + ~b + 1 so C means "no borrow".
  always_comb begin
    w_bb       = b ^ {WIDTH{op[0]}};
    w_sum      = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, op[0]};
    w_fast_res = {WIDTH{1'b0}};
    w_fast_c   = 1'b0;
    w_fast_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        w_fast_res = w_sum[WIDTH-1:0];
        w_fast_c   = w_sum[WIDTH];
        w_fast_v   = (a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:                           w_fast_res = a & b;
      OP_OR:                            w_fast_res = a | b;
      OP_MUL, OP_SDIV, OP_UDIV, OP_RSV: w_fast_res = {WIDTH{1'b0}};
      default:                          w_fast_res = {WIDTH{1'b0}};
    endcase
    w_fast_flags = nz_flags(w_fast_res, w_fast_c, w_fast_v);
  end

  assign w_mul_p = r_p + (r_q[0] ? r_d : {WIDTH{1'b0}});

`ifdef ALU_MC_DIV_EN
  logic             r_is_div;
  logic             r_sdiv;
  logic             r_neg;
  logic             r_dzp;
  logic             w_signed;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_sub;
  logic             w_qbit;
  logic [WIDTH-1:0] w_div_p;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_quo;

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] f_x);
    neg2 = ~f_x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Restoring step: r_p is the partial remainder, r_q shifts dividend out and quotient in.
  assign w_signed  = (op == OP_SDIV);
  assign w_rem_sh  = {r_p, r_q[WIDTH-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_d};
  assign w_qbit    = ~w_rem_sub[WIDTH];
  assign w_div_p   = w_qbit ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_div_q   = {r_q[WIDTH-2:0], w_qbit};
  assign w_quo     = r_neg ? neg2(w_div_q) : w_div_q;

  // Divider mode bits captured on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_sdiv   <= 1'b0;
      r_neg    <= 1'b0;
      r_dzp    <= 1'b0;
    end else if (w_accept) begin
      r_is_div <= (op == OP_SDIV) | (op == OP_UDIV);
      r_sdiv   <= w_signed;
      r_neg    <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_dzp    <= (b == {WIDTH{1'b0}});
    end
  end
`endif

  // Operand loading and per-iteration update for the multi-cycle unit.
  always_comb begin
    w_ld_q      = b;
    w_ld_d      = a;
    w_p_nxt     = w_mul_p;
    w_q_nxt     = r_q >> 1;
    w_d_nxt     = r_d << 1;
    w_run_res   = w_mul_p;
    w_run_flags = nz_flags(w_mul_p, 1'b0, 1'b0);
    w_run_dz    = 1'b0;
`ifdef ALU_MC_DIV_EN
    if (w_signed) begin
      w_ld_q = a[WIDTH-1] ? neg2(a) : a;
      w_ld_d = b[WIDTH-1] ? neg2(b) : b;
    end else if (op == OP_UDIV) begin
      w_ld_q = a;
      w_ld_d = b;
    end else begin
      w_ld_q = b;
      w_ld_d = a;
    end
    if (r_is_div) begin
      w_p_nxt = w_div_p;
      w_q_nxt = w_div_q;
      w_d_nxt = r_d;
      if (r_dzp) begin
        w_run_res   = {WIDTH{1'b1}};
        w_run_flags = nz_flags({WIDTH{1'b1}}, 1'b0, 1'b0);
        w_run_dz    = 1'b1;
      end else begin
        // A positive quotient with its MSB set only arises from MIN / -1.
        w_run_res   = w_quo;
        w_run_flags = nz_flags(w_quo, 1'b0, r_sdiv & ~r_neg & w_div_q[WIDTH-1]);
        w_run_dz    = 1'b0;
      end
    end else begin
      w_d_nxt = r_d << 1;
    end
`endif
  end

  // Datapath registers; result/flags/dz change only on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= {CW{1'b0}};
      r_p      <= {WIDTH{1'b0}};
      r_q      <= {WIDTH{1'b0}};
      r_d      <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_flags  <= 4'b0000;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= {CW{1'b0}};
      r_p   <= {WIDTH{1'b0}};
      r_q   <= w_ld_q;
      r_d   <= w_ld_d;
      if (!w_multi) begin
        r_result <= w_fast_res;
        r_flags  <= w_fast_flags;
        r_dz     <= 1'b0;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_p   <= w_p_nxt;
      r_q   <= w_q_nxt;
      r_d   <= w_d_nxt;
      if (w_last) begin
        r_result <= w_run_res;
        r_flags  <= w_run_flags;
        r_dz     <= w_run_dz;
      end
    end
  end

  assign result = r_result;
  assign flags  = r_flags;
  assign done   = r_done;
  assign busy   = r_busy;
  assign dz     = r_dz;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized self-checking bench for alu_mc (WIDTH=32) against an arithmetic reference model.
// Honors ALU_MC_DIV_EN: without it SDIV/UDIV are expected to behave as the reserved op.

module tb_alu_mc;

  localparam int W = 32;
`ifdef ALU_MC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         done;
  logic         busy;
  logic         dz;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .flags(flags), .done(done), .busy(busy), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic on the operands.
  function automatic void model(input logic [2:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                                output logic [W-1:0] m_r, output logic [3:0] m_f, output logic m_dz,
                                output int m_lat);
    longint      sa;
    longint      sb;
    longint      exact;
    logic [63:0] wide;
    logic        c;
    logic        v;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    c = 1'b0; v = 1'b0; m_dz = 1'b0; m_lat = 1; m_r = '0;
    case (m_op)
      3'd0: begin
        wide = {32'h0, m_a} + {32'h0, m_b};
        m_r = wide[W-1:0]; c = wide[32];
        exact = sa + sb; v = (exact != longint'($signed(m_r)));
      end
      3'd1: begin
        m_r = m_a - m_b; c = (m_a >= m_b);
        exact = sa - sb; v = (exact != longint'($signed(m_r)));
      end
      3'd2: m_r = m_a & m_b;
      3'd3: m_r = m_a | m_b;
      3'd6: begin
        wide = {32'h0, m_a} * {32'h0, m_b};
        m_r = wide[W-1:0]; m_lat = W + 1;
      end
      3'd4, 3'd5: begin
        if (DIV_EN) begin
          m_lat = W + 1;
          if (m_b == '0) begin
            m_r = '1; m_dz = 1'b1;
          end else if (m_op == 3'd5) begin
            m_r = m_a / m_b;
          end else if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
            m_r = m_a; v = 1'b1;
          end else begin
            m_r = 32'(sa / sb);
          end
        end
      end
      default: m_r = '0;
    endcase
    m_f = {m_r[W-1], (m_r == '0), c, v};
  endfunction

  // Issue one operation, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [2:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b, input bit noise,
                        output logic [W-1:0] r_o, output logic [3:0] f_o, output logic dz_o,
                        output int lat_o, output int busy_o, output int both_o);
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat_o = 1; busy_o = 0; both_o = 0;
    while (!done && lat_o < 200) begin
      if (busy) busy_o++;
      if (busy && done) both_o++;
      if (noise) begin
        start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      lat_o++;
    end
    start = 1'b0;
    if (busy && done) both_o++;
    r_o = result; f_o = flags; dz_o = dz;
  endtask

  task automatic test_reset;
    logic [W-1:0] ta, tb, er;
    logic [3:0]   ef;
    logic         ed;
    int           el;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({result, flags, done, busy, dz} !== {(W + 7){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_state: got r=%h f=%b done=%b busy=%b dz=%b, want all zero", result, flags, done, busy, dz);
    end
    @(negedge clk);
    reset = 1'b0;
    ta = $urandom; tb = $urandom;
    model(3'd0, ta, tb, er, ef, ed, el);
    start = 1'b1; op = 3'd0; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1 || result !== er || flags !== ef) begin
      n_fail++;
      $display("FAIL first_start: got done=%b r=%h f=%b, want done=1 r=%h f=%b", done, result, flags, er, ef);
    end
  endtask

  task automatic test_add_sub;
    logic [W-1:0] ta, tb, r, er;
    logic [2:0]   top;
    logic [3:0]   f, ef;
    logic         d, ed;
    int           lat, bz, both, el;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0:       begin top = 3'd0; ta = 32'hFFFF_FFFF; tb = 32'h1; end
        1:       begin top = 3'd1; ta = 32'h8000_0000; tb = 32'h1; end
        2:       begin top = 3'd0; ta = 32'h7FFF_FFFF; tb = 32'h1; end
        3:       begin top = 3'd1; ta = 32'h0;         tb = 32'h1; end
        4:       begin top = 3'd1; ta = 32'h1234_5678; tb = 32'h1234_5678; end
        default: begin top = 3'($urandom_range(1, 0)); ta = $urandom; tb = $urandom; end
      endcase
      model(top, ta, tb, er, ef, ed, el);
      run_op(top, ta, tb, 1'b0, r, f, d, lat, bz, both);
      n_tests++;
      if ({r, f, d} !== {er, ef, ed}) begin
        n_fail++;
        $display("FAIL add_sub[%0d] op=%0d a=%h b=%h: got r=%h f=%b dz=%b, want r=%h f=%b dz=%b",
                 i, top, ta, tb, r, f, d, er, ef, ed);
      end
      n_tests++;
      if (lat !== el || bz !== 0 || both !== 0) begin
        n_fail++;
        $display("FAIL add_sub_lat[%0d]: got lat=%0d busy=%0d both=%0d, want lat=%0d busy=0 both=0", i, lat, bz, both, el);
      end
      if (i == 0 || i == 1) begin
        n_tests++;
        if ({r, f} !== ((i == 0) ? {32'h0, 4'b0110} : {32'h7FFF_FFFF, 4'b0011})) begin
          n_fail++;
          $display("FAIL add_sub_directed[%0d]: got r=%h f=%b", i, r, f);
        end
      end
    end
  endtask

  task automatic test_logic;
    logic [W-1:0] ta, tb, r, er;
    logic [2:0]   top;
    logic [3:0]   f, ef;
    logic         d, ed;
    int           lat, bz, both, el;
    for (int i = 0; i < 15; i++) begin
      top = (i % 3 == 2) ? 3'd7 : 3'(2 + (i % 3));
      ta = $urandom; tb = (i == 0) ? ~ta : $urandom;
      model(top, ta, tb, er, ef, ed, el);
      run_op(top, ta, tb, 1'b0, r, f, d, lat, bz, both);
      n_tests++;
      if ({r, f, d} !== {er, ef, ed} || lat !== 1 || bz !== 0) begin
        n_fail++;
        $display("FAIL logic[%0d] op=%0d a=%h b=%h: got r=%h f=%b dz=%b lat=%0d, want r=%h f=%b dz=%b lat=1",
                 i, top, ta, tb, r, f, d, lat, er, ef, ed);
      end
    end
  endtask

  task automatic test_mul;
    logic [W-1:0] ta, tb, r, er;
    logic [3:0]   f, ef;
    logic         d, ed;
    int           lat, bz, both, el;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       begin ta = 32'h0001_0000; tb = 32'h0001_0001; end
        1:       begin ta = 32'hFFFF_FFFF; tb = 32'hFFFF_FFFF; end
        2:       begin ta = $urandom;      tb = 32'h0; end
        default: begin ta = $urandom;      tb = $urandom; end
      endcase
      model(3'd6, ta, tb, er, ef, ed, el);
      run_op(3'd6, ta, tb, 1'b1, r, f, d, lat, bz, both);
      n_tests++;
      if ({r, f, d} !== {er, ef, ed}) begin
        n_fail++;
        $display("FAIL mul[%0d] a=%h b=%h: got r=%h f=%b dz=%b, want r=%h f=%b dz=%b", i, ta, tb, r, f, d, er, ef, ed);
      end
      n_tests++;
      if (lat !== 33 || bz !== 32 || both !== 0) begin
        n_fail++;
        $display("FAIL mul_lat[%0d]: got lat=%0d busy=%0d both=%0d, want lat=33 busy=32 both=0", i, lat, bz, both);
      end
      if (i == 0) begin
        n_tests++;
        if ({r, f} !== {32'h0001_0000, 4'b0000}) begin
          n_fail++;
          $display("FAIL mul_directed: got r=%h f=%b, want r=00010000 f=0000", r, f);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== er) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b busy=%b r=%h, want done=0 busy=0 r=%h", done, busy, result, er);
    end
  endtask

  task automatic test_div;
    logic [W-1:0] ta, tb, r, er;
    logic [2:0]   top;
    logic [3:0]   f, ef;
    logic         d, ed;
    int           lat, bz, both, el;
    for (int i = 0; i < 20; i++) begin
      case (i)
        0:       begin top = 3'd4; ta = 32'hFFFF_FFF9; tb = 32'h2; end
        1:       begin top = 3'd5; ta = 32'd100;       tb = 32'h0; end
        2:       begin top = 3'd4; ta = 32'h8000_0000; tb = 32'hFFFF_FFFF; end
        3:       begin top = 3'd5; ta = 32'd9;         tb = 32'd3; end
        4:       begin top = 3'd4; ta = 32'd7;         tb = 32'hFFFF_FFFE; end
        5:       begin top = 3'd4; ta = $urandom;      tb = 32'h0; end
        6:       begin top = 3'd4; ta = 32'h8000_0000; tb = 32'h1; end
        default: begin
          top = 3'($urandom_range(5, 4)); ta = $urandom;
          tb = (i % 3 == 0) ? 32'($urandom_range(9, 0)) : $urandom;
        end
      endcase
      model(top, ta, tb, er, ef, ed, el);
      run_op(top, ta, tb, 1'b1, r, f, d, lat, bz, both);
      n_tests++;
      if ({r, f, d} !== {er, ef, ed}) begin
        n_fail++;
        $display("FAIL div[%0d] op=%0d a=%h b=%h: got r=%h f=%b dz=%b, want r=%h f=%b dz=%b",
                 i, top, ta, tb, r, f, d, er, ef, ed);
      end
      n_tests++;
      if (lat !== el || bz !== el - 1 || both !== 0) begin
        n_fail++;
        $display("FAIL div_lat[%0d]: got lat=%0d busy=%0d both=%0d, want lat=%0d busy=%0d", i, lat, bz, both, el, el - 1);
      end
      if (i < 4) begin
        n_tests++;
        if ({r, f, d} !== (!DIV_EN ? {32'h0, 4'b0100, 1'b0} :
                           (i == 0) ? {32'hFFFF_FFFD, 4'b1000, 1'b0} :
                           (i == 1) ? {32'hFFFF_FFFF, 4'b1000, 1'b1} :
                           (i == 2) ? {32'h8000_0000, 4'b1001, 1'b0} : {32'h3, 4'b0000, 1'b0})) begin
          n_fail++;
          $display("FAIL div_directed[%0d]: got r=%h f=%b dz=%b", i, r, f, d);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ta, tb, r, er;
    logic [2:0]   top;
    logic [3:0]   f, ef;
    logic         d, ed;
    int           lat, bz, both, el;
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, f, d, lat, bz, both);
    n_tests++;
    if (f[0] !== DIV_EN || r !== (DIV_EN ? 32'h8000_0000 : 32'h0)) begin
      n_fail++;
      $display("FAIL b2b_sdiv_ovf: got r=%h V=%b, want V=%b", r, f[0], DIV_EN);
    end
    for (int i = 0; i < 6; i++) begin
      top = 3'($urandom_range(3, 0)); ta = $urandom; tb = $urandom;
      model(top, ta, tb, er, ef, ed, el);
      start = 1'b1; op = top; a = ta; b = tb;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== er || flags !== ef) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%0d: got done=%b busy=%b r=%h f=%b, want done=1 busy=0 r=%h f=%b",
                 i, top, done, busy, result, flags, er, ef);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         d;
    int           lat, bz, both, saw_done;
    run_op(3'd0, 32'h1, 32'h1, 1'b0, r, f, d, lat, bz, both);
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 32'h2) begin
      n_fail++;
      $display("FAIL mid_run_busy: got busy=%b done=%b r=%h, want busy=1 done=0 r=00000002", busy, done, result);
    end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({result, flags, done, busy, dz} !== {(W + 7){1'b0}}) begin
      n_fail++;
      $display("FAIL async_reset: got r=%h f=%b done=%b busy=%b dz=%b, want all zero", result, flags, done, busy, dz);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1 || result !== 32'd5 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_add: got done=%b r=%h f=%b, want done=1 r=00000005 f=0000", done, result, flags);
    end
    saw_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done++;
    end
    n_tests++;
    if (saw_done !== 0) begin
      n_fail++;
      $display("FAIL abandoned_op: got %0d cycles with done/busy after reset, want 0", saw_done);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    test_reset;
    test_add_sub;
    test_logic;
    test_mul;
    test_div;
    test_back_to_back;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
- REQ-001: Parameter WIDTH, default 32, sets operand/result width (legal 8..64, even).
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: start  input  1  request; sampled only when busy=0.
- REQ-005: op  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SDIV, 101 UDIV, 110 MUL, 111 reserved.
- REQ-006: a, b  input  WIDTH  operands; captured on the accepting edge.
- REQ-007: result  output  WIDTH  registered result, held until the next completion.
- REQ-008: flags  output  4  registered {N,Z,C,V}, updated with result.
- REQ-009: done  output  1  one-cycle completion pulse.
- REQ-010: busy  output  1  high while an accepted operation is in progress.
- REQ-011: dz  output  1  divide-by-zero indicator, updated with result.

Function
- REQ-012: FSM states IDLE, RUN, DONE; IDLE->RUN on accepted start of MUL/DIV, IDLE->DONE on accepted start of ADD/SUB/AND/OR/reserved, RUN->DONE after the last iteration, DONE->IDLE unless start is high.
- REQ-013: A start is accepted on an edge where start=1 and state is IDLE or DONE; start with busy=1 is ignored and not queued.
- REQ-014: Latency from the accepting edge to done=1: 1 cycle for ADD/SUB/AND/OR/reserved, WIDTH+1 cycles for MUL, SDIV, UDIV.
- REQ-015: busy is 1 in RUN only; done is 1 in DONE only; busy and done are never both 1.
- REQ-016: A start accepted in DONE begins the new operation at that edge (back-to-back, no idle cycle).
- REQ-017: ADD/SUB: result = a + (op[0] ? ~b : b) + op[0] modulo 2^WIDTH; C = carry out of bit WIDTH-1; V = signed overflow.
- REQ-018: AND/OR: bitwise; C=V=0.
- REQ-019: MUL: iterative shift-add, one bit of b per cycle; result = low WIDTH bits of a*b; C=V=0.
- REQ-020: UDIV: restoring division, one quotient bit per cycle; result = floor(a/b).
- REQ-021: SDIV: divide magnitudes, negate quotient when sign(a) != sign(b); rounds toward zero; C=V=0.
- REQ-022: b=0 on UDIV/SDIV: result = all ones, dz=1, latency unchanged; dz=0 for every other completion.
- REQ-023: SDIV with a = most-negative and b = -1: result = a, V=1.
- REQ-024: N = result[WIDTH-1], Z = (result==0) for all ops; reserved op yields result 0, flags 0100.
- REQ-025: a, b, op changes after acceptance have no effect on the operation in progress.

Reset
- REQ-026: reset=1 forces state IDLE, result 0, flags 0, done 0, busy 0, dz 0 immediately, regardless of clk.
- REQ-027: reset during RUN abandons the operation; no done pulse is produced for it.
- REQ-028: First start is accepted on the first rising edge after reset deasserts.

Configuration
- REQ-029: Macro ALU_MC_DIV_EN compiles in the iterative divider (SDIV/UDIV per REQ-020..023).
- REQ-030: Without ALU_MC_DIV_EN, SDIV/UDIV behave as reserved: 1-cycle latency, result 0, flags 0100, dz 0; no divider logic is synthesised.

Verification (WIDTH=32, ALU_MC_DIV_EN defined unless stated)
- REQ-031: ADD a=0xFFFFFFFF, b=1 -> done 1 cycle later, result 0, flags 0110; SUB a=0x80000000, b=1 -> result 0x7FFFFFFF, flags 0011.
- REQ-032: MUL a=0x10000, b=0x10001 -> busy 32 cycles, done at cycle 33, result 0x00010000, flags 0000; start pulses during busy ignored.
- REQ-033: SDIV a=-7, b=2 -> result 0xFFFFFFFD, flags 1000; UDIV a=100, b=0 -> result 0xFFFFFFFF, dz=1 at cycle 33.
- REQ-034: SDIV a=0x80000000, b=0xFFFFFFFF -> result 0x80000000, V=1; back-to-back ADD started in DONE completes one cycle later.
- REQ-035: reset asserted mid-MUL (cycle 10) -> outputs 0 asynchronously, no done; new ADD 2+3 after release -> result 5.
- REQ-036: Build without ALU_MC_DIV_EN: UDIV 9/3 -> done after 1 cycle, result 0, flags 0100.
